// File: rtl/shift_register_reader.sv
// Reads a 74HC165-style PISO chain: load pulse, DATA_WIDTH shift clocks, MSB first.
// Optional SR_READER_CHANGE_DETECT_EN: dataValid only on a changed word or first read.
module shift_register_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  readReq,
    input  logic                  serialIn,
    output logic                  loadN,
    output logic                  shiftClk,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValid,
    output logic                  busy
);

    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BITS_ALL = BW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PW-1:0]         r_phase;
    logic [PW-1:0]         w_phase_nxt;
    logic [BW-1:0]         r_bits;
    logic [BW-1:0]         w_bits_nxt;
    logic [BW-1:0]         w_bits_inc;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_last;
    logic                  w_valid_nxt;
    logic                  w_busy_nxt;

    assign w_last     = (r_phase == PH_LAST);
    assign w_bits_inc = r_bits + BW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bits_nxt  = r_bits;
        w_shift_nxt = r_shift;
        unique case (r_state)
            S_IDLE: begin
                w_phase_nxt = '0;
                if (readReq) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_bits_nxt = '0;
                if (w_last) begin
                    w_phase_nxt = '0;
                    w_state_nxt = S_SHIFT_LO;
                end else begin
                    w_phase_nxt = r_phase + PW'(1);
                end
            end
            S_SHIFT_LO: begin
                if (w_last) begin
                    w_phase_nxt = '0;
                    w_shift_nxt = {r_shift[DATA_WIDTH-2:0], serialIn};
                    w_state_nxt = S_SHIFT_HI;
                end else begin
                    w_phase_nxt = r_phase + PW'(1);
                end
            end
            S_SHIFT_HI: begin
                if (w_last) begin
                    w_phase_nxt = '0;
                    w_bits_nxt  = w_bits_inc;
                    if (w_bits_inc == BITS_ALL) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SHIFT_LO;
                    end
                end else begin
                    w_phase_nxt = r_phase + PW'(1);
                end
            end
            S_DONE: begin
                w_phase_nxt = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_phase_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef SR_READER_CHANGE_DETECT_EN
    logic r_first;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_first <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_first <= 1'b0;
        end
    end

    assign w_valid_nxt = (r_state == S_DONE) &&
                         (r_first || (r_shift != dataOut));
`else
    assign w_valid_nxt = (r_state == S_DONE);
`endif

    // busy stays up through the dataValid cycle, which is spent in IDLE
    assign w_busy_nxt = (w_state_nxt != S_IDLE) || (r_state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_bits    <= '0;
            r_shift   <= '0;
            loadN     <= 1'b1;
            shiftClk  <= 1'b0;
            dataOut   <= '0;
            dataValid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_bits    <= w_bits_nxt;
            r_shift   <= w_shift_nxt;
            loadN     <= (w_state_nxt != S_LOAD);
            shiftClk  <= (w_state_nxt == S_SHIFT_HI);
            dataValid <= w_valid_nxt;
            busy      <= w_busy_nxt;
            if (r_state == S_DONE) begin
                dataOut <= r_shift;
            end
        end
    end

endmodule

// File: tb/tb_shift_register_reader.sv
// Bench for shift_register_reader: cycle model for the default build plus a
// CLK_DIV=1 / DATA_WIDTH=16 instance with directed checks.
module tb_shift_register_reader;

    localparam int C  = 4;
    localparam int W  = 8;
    localparam int L  = C * (2 * W + 1) + 1;
    localparam int W2 = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic          readReq1 = 1'b0;
    logic          serialIn1;
    logic          loadN1, shiftClk1, dataValid1, busy1;
    logic [W-1:0]  dataOut1;
    logic [W-1:0]  par1 = '0;
    logic [W-1:0]  ext1 = '0;

    logic          readReq2 = 1'b0;
    logic          serialIn2;
    logic          loadN2, shiftClk2, dataValid2, busy2;
    logic [W2-1:0] dataOut2;
    logic [W2-1:0] par2 = '0;
    logic [W2-1:0] ext2 = '0;

    int n_assert = 0;
    int n_fail   = 0;
    int nload1 = 0, nsclk1 = 0, nsclk2 = 0;

    always #5 clk = ~clk;

    shift_register_reader #(.DATA_WIDTH(W), .CLK_DIV(C)) u_dut (
        .clk(clk), .reset(reset), .readReq(readReq1),
        .serialIn(serialIn1), .loadN(loadN1), .shiftClk(shiftClk1),
        .dataOut(dataOut1), .dataValid(dataValid1), .busy(busy1)
    );

    shift_register_reader #(.DATA_WIDTH(W2), .CLK_DIV(1)) u_dut2 (
        .clk(clk), .reset(reset), .readReq(readReq2),
        .serialIn(serialIn2), .loadN(loadN2), .shiftClk(shiftClk2),
        .dataOut(dataOut2), .dataValid(dataValid2), .busy(busy2)
    );

    assign serialIn1 = ext1[W-1];
    assign serialIn2 = ext2[W2-1];

    // External 74HC165 behaviour
    initial forever begin
        @(negedge loadN1 or posedge shiftClk1);
        if (!loadN1) begin
            ext1 = par1;
            nload1++;
        end else if (shiftClk1) begin
            ext1 = {ext1[W-2:0], 1'b0};
            nsclk1++;
        end
    end

    initial forever begin
        @(negedge loadN2 or posedge shiftClk2);
        if (!loadN2) begin
            ext2 = par2;
        end else if (shiftClk2) begin
            ext2 = {ext2[W2-2:0], 1'b0};
            nsclk2++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: k = cycles since the acceptance edge
    bit           m_act = 1'b0;
    int           m_k = 0;
    bit           m_first = 1'b1;
    bit           m_vld = 1'b0;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_out = '0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_act = 0; m_k = 0; m_out = '0; m_first = 1; m_vld = 0;
        end else if (m_act && m_k == L) begin
            if (readReq1) begin
                m_k = 0;
                m_word = par1;
            end else begin
                m_act = 0;
            end
        end else if (m_act) begin
            m_k++;
            if (m_k == L) begin
`ifdef SR_READER_CHANGE_DETECT_EN
                m_vld = m_first || (m_word != m_out);
`else
                m_vld = 1;
`endif
                m_out = m_word;
                m_first = 0;
            end
        end else if (readReq1) begin
            m_act = 1;
            m_k = 0;
            m_word = par1;
        end
    end

    initial forever begin
        logic e_ld, e_sc;
        @(negedge clk);
        e_ld = !(m_act && m_k < C);
        e_sc = m_act && m_k >= C && m_k < C + 2 * W * C &&
               (((m_k - C) / C) % 2 == 1);
        chk("cyc loadN", loadN1, e_ld);
        chk("cyc shiftClk", shiftClk1, e_sc);
        chk("cyc busy", busy1, m_act);
        chk("cyc dataValid", dataValid1, m_act && m_k == L && m_vld);
        chk("cyc dataOut", dataOut1, m_out);
    end

    task automatic read1(input logic [W-1:0] w, input bit extra,
                         output int nv, output int lat,
                         output logic [W-1:0] dout);
        int cyc;
        par1 = w;
        nv = 0;
        lat = -1;
        dout = dataOut1;
        @(negedge clk) readReq1 = 1'b1;
        @(negedge clk) readReq1 = 1'b0;
        cyc = 0;
        while (busy1 && cyc < 300) begin
            if (dataValid1) begin
                nv++;
                lat = cyc;
                dout = dataOut1;
            end
            if (extra && cyc == 20) readReq1 = 1'b1;
            if (extra && cyc == 21) readReq1 = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk("read1 timeout", busy1, 1'b0);
    endtask

    task automatic read2(input logic [W2-1:0] w, output int nv,
                         output int lat, output logic [W2-1:0] dout);
        int cyc;
        par2 = w;
        nv = 0;
        lat = -1;
        dout = dataOut2;
        @(negedge clk) readReq2 = 1'b1;
        @(negedge clk) readReq2 = 1'b0;
        cyc = 0;
        while (busy2 && cyc < 300) begin
            if (dataValid2) begin
                nv++;
                lat = cyc;
                dout = dataOut2;
            end
            @(negedge clk);
            cyc++;
        end
        chk("read2 timeout", busy2, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nv, lat, l0, s0, cyc, got, v1, v2, cnt;
        logic [W-1:0]  d, d1, d2;
        logic [W2-1:0] dd;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Abort in the middle of a high shift phase
        par1 = 8'h5A;
        @(negedge clk) readReq1 = 1'b1;
        @(negedge clk) readReq1 = 1'b0;
        cnt = 0;
        while (!shiftClk1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("t1 reached shift high", shiftClk1, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("t1 rst loadN", loadN1, 1'b1);
        chk("t1 rst shiftClk", shiftClk1, 1'b0);
        chk("t1 rst dataOut", dataOut1, 8'h00);
        chk("t1 rst dataValid", dataValid1, 1'b0);
        chk("t1 rst busy", busy1, 1'b0);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1 idle after release", busy1, 1'b0);

        l0 = nload1; s0 = nsclk1;
        read1(8'hA5, 1'b0, nv, lat, d);
        chk("t2 valid count", nv, 1);
        chk("t2 latency", lat, 69);
        chk("t2 dataOut", d, 8'hA5);
        chk("t2 load pulses", nload1 - l0, 1);
        chk("t2 shift pulses", nsclk1 - s0, 8);

        l0 = nload1; s0 = nsclk1;
        read1(8'h96, 1'b1, nv, lat, d);
        repeat (10) @(negedge clk);
        chk("t3 valid count", nv, 1);
        chk("t3 dataOut", d, 8'h96);
        chk("t3 load pulses", nload1 - l0, 1);
        chk("t3 shift pulses", nsclk1 - s0, 8);
        chk("t3 stays idle", busy1, 1'b0);

        // Request held high across two reads
        par1 = 8'h01;
        @(negedge clk) readReq1 = 1'b1;
        cyc = 0; got = 0; v1 = -1; v2 = -1; d1 = '0; d2 = '0;
        while (cyc < 300 && got < 2) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) par1 = 8'h80;
            if (dataValid1) begin
                if (got == 0) begin
                    v1 = cyc; d1 = dataOut1;
                end else begin
                    v2 = cyc; d2 = dataOut1; readReq1 = 1'b0;
                end
                got++;
            end
        end
        readReq1 = 1'b0;
        chk("t4 two reads", got, 2);
        chk("t4 valid spacing", v2 - v1, 70);
        chk("t4 first word", d1, 8'h01);
        chk("t4 second word", d2, 8'h80);
        cnt = 0;
        while (busy1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("t4 busy drops", busy1, 1'b0);

        read1(8'h3C, 1'b0, nv, lat, d);
        chk("t6 read1 valid", nv, 1);
        read1(8'h3C, 1'b0, nv, lat, d);
`ifdef SR_READER_CHANGE_DETECT_EN
        chk("t6 read2 valid", nv, 0);
`else
        chk("t6 read2 valid", nv, 1);
`endif
        read1(8'hC3, 1'b0, nv, lat, d);
        chk("t6 read3 valid", nv, 1);
        chk("t6 read3 dataOut", dataOut1, 8'hC3);

        s0 = nsclk2;
        read2(16'hBEEF, nv, lat, dd);
        chk("t5 valid count", nv, 1);
        chk("t5 latency", lat, 34);
        chk("t5 dataOut", dd, 16'hBEEF);
        chk("t5 shift pulses", nsclk2 - s0, 16);
        read2(16'h8001, nv, lat, dd);
        chk("t5b dataOut", dd, 16'h8001);
        chk("t5b latency", lat, 34);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
